game_state_ctrl: RTL and testbench

- Upstream of the start-screen blink mux.
- Top-level game-flow controller.
- Produces the 2-bit gameState and the free-running 6-bit FrameCount consumed by the start-screen overlay, sprite and scroll logic.
- Owns the debounced start button, the lives counter, post-hit invulnerability, and the timed end-screen hold.

---
 rtl/game_state_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl
//  Purpose  : Top-level game-flow controller. Drives gameState (START/PLAY/
//             OVER/WIN), the free-running FrameCount, the lives counter,
//             post-hit invulnerability, the end-screen hold timer, and a
//             debounced start button.
//  Options  : GAME_STATE_PAUSE_EN adds pause_btn / paused (debounced pause
//             toggle while in PLAY).
//  Revision : 1.0 - initial release
// ============================================================================

// Debouncer: the accepted level changes only after FRAMES consecutive
// samples that differ from it; press_o pulses for one cycle on a 0->1 change.
module game_state_debounce #(
  parameter int FRAMES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (FRAMES < 2) ? 1 : $clog2(FRAMES + 1);

  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          press_q;

  // Count disagreeing samples; accept the new level on the FRAMES-th one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (btn_i == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FRAMES - 1)) begin
        cnt_q    <= '0;
        stable_q <= btn_i;
        press_q  <= btn_i;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

module game_state_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int RESPAWN_FRAMES  = 120,
  parameter int END_HOLD_FRAMES = 240
) (
  input  logic       frame_Clk,
  input  logic       Reset,
`ifdef GAME_STATE_PAUSE_EN
  input  logic       pause_btn,
  output logic       paused,
`endif
  input  logic       start_btn,
  input  logic       player_hit,
  input  logic       level_clear,
  output logic [1:0] gameState,
  output logic [5:0] FrameCount,
  output logic [1:0] lives,
  output logic       invuln,
  output logic       game_reset,
  output logic       respawn
);

  localparam int RESP_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

  localparam logic [RESP_W-1:0] RESP_LOAD  = RESP_W'(RESPAWN_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(END_HOLD_FRAMES);
  localparam logic [1:0]        LIVES_LOAD = 2'(LIVES_INIT);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_WIN   = 2'b11
  } state_t;

  state_t            state_q;
  logic [5:0]        frame_cnt_q;
  logic [1:0]        lives_q;
  logic [RESP_W-1:0] resp_tmr_q;
  logic [RESP_W-1:0] resp_tmr_d;
  logic [HOLD_W-1:0] hold_q;
  logic              invuln_q;
  logic              game_reset_q;
  logic              respawn_q;
  logic              start_press;
  logic              frozen;

  game_state_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_start_db (
    .clk_i   (frame_Clk),
    .rst_i   (Reset),
    .btn_i   (start_btn),
    .press_o (start_press)
  );

`ifdef GAME_STATE_PAUSE_EN
  logic pause_press;
  logic paused_q;

  game_state_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_pause_db (
    .clk_i   (frame_Clk),
    .rst_i   (Reset),
    .btn_i   (pause_btn),
    .press_o (pause_press)
  );

  assign frozen = paused_q;
  assign paused = paused_q;
`else
  assign frozen = 1'b0;
`endif

  // Free-running frame counter; never stalls, wraps naturally at 63.
  always_ff @(posedge frame_Clk) begin
    if (Reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_q + 6'd1;
  end

  // Saturating decrement of the respawn timer.
  always_comb begin
    resp_tmr_d = resp_tmr_q;
    if (resp_tmr_q != '0) resp_tmr_d = resp_tmr_q - 1'b1;
  end

  // Game-flow state machine with registered outputs.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_q      <= ST_START;
      lives_q      <= '0;
      resp_tmr_q   <= '0;
      hold_q       <= '0;
      invuln_q     <= 1'b0;
      game_reset_q <= 1'b0;
      respawn_q    <= 1'b0;
`ifdef GAME_STATE_PAUSE_EN
      paused_q     <= 1'b0;
`endif
    end else begin
      game_reset_q <= 1'b0;
      respawn_q    <= 1'b0;
`ifdef GAME_STATE_PAUSE_EN
      if (state_q != ST_PLAY) paused_q <= 1'b0;
      else if (pause_press)   paused_q <= ~paused_q;
`endif
      unique case (state_q)
        ST_START: begin
          if (start_press) begin
            state_q      <= ST_PLAY;
            lives_q      <= LIVES_LOAD;
            resp_tmr_q   <= RESP_LOAD;
            invuln_q     <= (RESP_LOAD != '0);
            game_reset_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (!frozen) begin
            // Level end wins over a simultaneous hit; the timer is cleared on
            // exit so invulnerability never leaks into the end screens.
            if (level_clear) begin
              state_q    <= ST_WIN;
              hold_q     <= HOLD_LOAD;
              resp_tmr_q <= '0;
              invuln_q   <= 1'b0;
`ifdef GAME_STATE_PAUSE_EN
              paused_q   <= 1'b0;
`endif
            end else if (player_hit && !invuln_q) begin
              if (lives_q <= 2'd1) begin
                state_q    <= ST_OVER;
                lives_q    <= '0;
                hold_q     <= HOLD_LOAD;
                resp_tmr_q <= '0;
                invuln_q   <= 1'b0;
`ifdef GAME_STATE_PAUSE_EN
                paused_q   <= 1'b0;
`endif
              end else begin
                lives_q    <= lives_q - 2'd1;
                resp_tmr_q <= RESP_LOAD;
                invuln_q   <= (RESP_LOAD != '0);
                respawn_q  <= 1'b1;
              end
            end else begin
              resp_tmr_q <= resp_tmr_d;
              invuln_q   <= (resp_tmr_d != '0);
            end
          end
        end
        ST_OVER, ST_WIN: begin
          // start_press is deliberately ignored here so the losing press
          // cannot skip the end screen.
          if (hold_q <= HOLD_W'(1)) begin
            state_q <= ST_START;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign gameState  = state_q;
  assign FrameCount = frame_cnt_q;
  assign lives      = lives_q;
  assign invuln     = invuln_q;
  assign game_reset = game_reset_q;
  assign respawn    = respawn_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_ctrl
//  Purpose  : Directed self-checking bench for game_state_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_state_ctrl;

  logic       frame_Clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       start_btn = 1'b0;
  logic       player_hit = 1'b0;
  logic       level_clear = 1'b0;
  logic [1:0] gameState;
  logic [5:0] FrameCount;
  logic [1:0] lives;
  logic       invuln;
  logic       game_reset;
  logic       respawn;
`ifdef GAME_STATE_PAUSE_EN
  logic       pause_btn = 1'b0;
  logic       paused;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;

  always #5 frame_Clk = ~frame_Clk;

  game_state_ctrl dut (
    .frame_Clk   (frame_Clk),
    .Reset       (Reset),
`ifdef GAME_STATE_PAUSE_EN
    .pause_btn   (pause_btn),
    .paused      (paused),
`endif
    .start_btn   (start_btn),
    .player_hit  (player_hit),
    .level_clear (level_clear),
    .gameState   (gameState),
    .FrameCount  (FrameCount),
    .lives       (lives),
    .invuln      (invuln),
    .game_reset  (game_reset),
    .respawn     (respawn)
  );

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; model FrameCount; land 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_Clk);
      if (Reset) exp_fc = 0;
      else       exp_fc = (exp_fc + 1) % 64;
      #1;
    end
  endtask

  initial begin
    // ---- 1: reset and FrameCount wrap ----
    tick(2);
    check_val("rst_state", gameState, 0);
    check_val("rst_fc", FrameCount, 0);
    check_val("rst_lives", lives, 0);
    check_val("rst_invuln", invuln, 0);
    check_val("rst_greset", game_reset, 0);
    check_val("rst_respawn", respawn, 0);
    Reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      check_val("fc_run", FrameCount, i % 64);
      tick(1);
    end
    check_val("fc_after70", FrameCount, 6);
    check_val("idle_state", gameState, 0);

    // ---- 2: glitch rejected, held press starts the game ----
    start_btn = 1'b1;
    tick(2);
    start_btn = 1'b0;
    tick(1);
    tick(3);
    check_val("glitch_state", gameState, 0);
    start_btn = 1'b1;
    tick(3);
    check_val("press_lat_state", gameState, 0);
    tick(1);
    check_val("start_state", gameState, 1);
    check_val("start_greset", game_reset, 1);
    check_val("start_lives", lives, 3);
    check_val("start_invuln", invuln, 1);
    tick(1);
    check_val("greset_single", game_reset, 0);
    tick(118);
    check_val("invuln_last", invuln, 1);
    tick(1);
    check_val("invuln_expired", invuln, 0);
    check_val("held_state", gameState, 1);

    // ---- 3: hit 3->2, second hit during invuln ignored ----
    start_btn  = 1'b0;
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check_val("hit1_lives", lives, 2);
    check_val("hit1_respawn", respawn, 1);
    check_val("hit1_invuln", invuln, 1);
    tick(1);
    check_val("respawn_single", respawn, 0);
    tick(8);
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check_val("hit_ignored_lives", lives, 2);
    check_val("hit_ignored_resp", respawn, 0);
    tick(110);
    check_val("hit1_invuln_end", invuln, 0);

    // ---- 4: down to one life, fatal hit, hold with ignored press ----
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check_val("hit2_lives", lives, 1);
    tick(120);
    check_val("hit2_invuln_end", invuln, 0);
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check_val("over_state", gameState, 2);
    check_val("over_lives", lives, 0);
    start_btn = 1'b1;
    tick(10);
    start_btn = 1'b0;
    check_val("over_press_ignored", gameState, 2);
    tick(229);
    check_val("over_hold_last", gameState, 2);
    check_val("over_lives_held", lives, 0);
    tick(1);
    check_val("over_exit", gameState, 0);
    check_val("fc_model_mid", FrameCount, exp_fc);

    // ---- 5: simultaneous hit and clear with one life -> WIN ----
    start_btn = 1'b1;
    tick(4);
    start_btn = 1'b0;
    check_val("game2_state", gameState, 1);
    check_val("game2_lives", lives, 3);
    tick(120);
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    tick(120);
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check_val("game2_lives1", lives, 1);
    tick(120);
    check_val("game2_invuln", invuln, 0);
    player_hit  = 1'b1;
    level_clear = 1'b1;
    tick(1);
    player_hit  = 1'b0;
    level_clear = 1'b0;
    check_val("win_state", gameState, 3);
    check_val("win_lives", lives, 1);
    tick(239);
    check_val("win_hold_last", gameState, 3);
    tick(1);
    check_val("win_exit", gameState, 0);

    // ---- 6: reset mid-game while invulnerable ----
    start_btn = 1'b1;
    tick(4);
    check_val("game3_state", gameState, 1);
    tick(5);
    check_val("game3_invuln", invuln, 1);
    start_btn = 1'b0;
    Reset     = 1'b1;
    tick(1);
    Reset     = 1'b0;
    check_val("mrst_state", gameState, 0);
    check_val("mrst_lives", lives, 0);
    check_val("mrst_invuln", invuln, 0);
    check_val("mrst_fc", FrameCount, 0);
    tick(3);
    check_val("post_rst_fc", FrameCount, exp_fc);
    check_val("post_rst_state", gameState, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
